// File: rtl/mem_arb_pkg.sv
// Shared types and helpers for the data-memory port arbiter and the issue buffers.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package mem_arb_pkg;

    localparam int ADDR_W_DEF  = 32;
    localparam int DATA_W_DEF  = 32;
    localparam int TAG_W_DEF   = 32;
    localparam int TIMEOUT_DEF = 255;

    // Widest instruction number tag_older can compare; callers zero-extend.
    localparam int TAG_MAX_W   = 64;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

    typedef enum logic {
        OP_LD = 1'b0,
        OP_ST = 1'b1
    } op_t;

    // True when instruction number a is strictly older than b on a ring of
    // 2^w numbers: the w-bit difference a-b, read as signed, is negative.
    // The difference is shifted up so its bit w-1 lands in the top bit,
    // which keeps the index constant for any w.
    function automatic logic tag_older(input logic [TAG_MAX_W-1:0] a,
                                       input logic [TAG_MAX_W-1:0] b,
                                       input int                   w);
        logic [TAG_MAX_W-1:0] diff;
        diff = (a - b) << (TAG_MAX_W - w);
        return diff[TAG_MAX_W-1];
    endfunction

endpackage

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single data-memory port between load and store issue heads, oldest first.
// Latency: accept edge N -> mem_req from N+1; ack at edge M -> done during M+1; timeout after TIMEOUT wait cycles.
// Backpressure: ld_ready/st_ready low while a memory access is outstanding; done has no backpressure.
//
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   ld_req/ld_addr/ld_tag        load head; ld_ready accepts it at the edge
//   st_req/st_addr/st_data/st_tag store head; st_ready accepts it at the edge
//   mem_req/mem_we/mem_addr/mem_wdata  memory request, held stable until mem_ack
//   mem_rdata/mem_ack            memory completion (one-cycle ack, data valid with it)
//   done/done_is_st/done_tag/done_data/done_err  one-cycle completion toward ROB/CDB
//   tag_clash                    sticky flag: both heads requested with equal tags
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int TAG_W   = TAG_W_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              ld_req,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [TAG_W-1:0]  ld_tag,
    output logic              ld_ready,

    input  logic              st_req,
    input  logic [ADDR_W-1:0] st_addr,
    input  logic [DATA_W-1:0] st_data,
    input  logic [TAG_W-1:0]  st_tag,
    output logic              st_ready,

    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,

    output logic              done,
    output logic              done_is_st,
    output logic [TAG_W-1:0]  done_tag,
    output logic [DATA_W-1:0] done_data,
    output logic              done_err,
    output logic              tag_clash
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    // The in-flight access; address and write data live in the mem_* registers.
    typedef struct packed {
        op_t              op;
        logic [TAG_W-1:0] tag;
    } inflight_t;

    state_t           state_q, state_d;
    inflight_t        cur_q;
    logic [CNT_W-1:0] cnt_q;

    logic sel_st;
    logic accept;
    logic complete;
    logic timed_out;

    // Selection. The store wins unless the load is strictly older, so equal
    // tags resolve to the store. Readies are suppressed outside IDLE and
    // during reset, which keeps them mutually exclusive.
    always_comb begin
        sel_st   = st_req && !(ld_req && tag_older(TAG_MAX_W'(ld_tag), TAG_MAX_W'(st_tag), TAG_W));
        st_ready = (state_q == IDLE) && !rst && sel_st;
        ld_ready = (state_q == IDLE) && !rst && ld_req && !sel_st;
        accept   = ld_ready || st_ready;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state. An ack on the final counted cycle still completes normally.
    always_comb begin
        state_d   = state_q;
        complete  = 1'b0;
        timed_out = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (mem_ack) begin
                    complete = 1'b1;
                    state_d  = IDLE;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    complete  = 1'b1;
                    timed_out = 1'b1;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cur_q      <= '0;
            cnt_q      <= '0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            done       <= 1'b0;
            done_is_st <= 1'b0;
            done_tag   <= '0;
            done_data  <= '0;
            done_err   <= 1'b0;
            tag_clash  <= 1'b0;
        end else begin
            done       <= 1'b0;
            done_is_st <= 1'b0;
            done_err   <= 1'b0;

            if (ld_req && st_req && (ld_tag == st_tag)) begin
                tag_clash <= 1'b1;
            end

            if (st_ready) begin
                cur_q.op  <= OP_ST;
                cur_q.tag <= st_tag;
                mem_req   <= 1'b1;
                mem_we    <= 1'b1;
                mem_addr  <= st_addr;
                mem_wdata <= st_data;
                cnt_q     <= '0;
            end else if (ld_ready) begin
                cur_q.op  <= OP_LD;
                cur_q.tag <= ld_tag;
                mem_req   <= 1'b1;
                mem_we    <= 1'b0;
                mem_addr  <= ld_addr;
                mem_wdata <= '0;
                cnt_q     <= '0;
            end

            if (state_q == WAIT) begin
                if (complete) begin
                    mem_req    <= 1'b0;
                    done       <= 1'b1;
                    done_is_st <= (cur_q.op == OP_ST);
                    done_tag   <= cur_q.tag;
                    done_err   <= timed_out;
                    done_data  <= (!timed_out && cur_q.op == OP_LD) ? mem_rdata : '0;
                end else begin
                    cnt_q <= cnt_q + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
`timescale 1ns/1ps
module tb_mem_port_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TW = 32;
    localparam int TO = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          ld_req = 1'b0;
    logic [AW-1:0] ld_addr = '0;
    logic [TW-1:0] ld_tag = '0;
    logic          ld_ready;
    logic          st_req = 1'b0;
    logic [AW-1:0] st_addr = '0;
    logic [DW-1:0] st_data = '0;
    logic [TW-1:0] st_tag = '0;
    logic          st_ready;
    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata = '0;
    logic          mem_ack = 1'b0;
    logic          done;
    logic          done_is_st;
    logic [TW-1:0] done_tag;
    logic [DW-1:0] done_data;
    logic          done_err;
    logic          tag_clash;

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TAG_W(TW), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .ld_req(ld_req), .ld_addr(ld_addr), .ld_tag(ld_tag), .ld_ready(ld_ready),
        .st_req(st_req), .st_addr(st_addr), .st_data(st_data), .st_tag(st_tag), .st_ready(st_ready),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .done(done), .done_is_st(done_is_st), .done_tag(done_tag), .done_data(done_data),
        .done_err(done_err), .tag_clash(tag_clash)
    );

    // One memory operation: what the issue buffer offers plus how the memory
    // model treats it (ack on WAIT cycle dly, reset on WAIT cycle rst_at, 0 = never).
    typedef struct {
        logic        is_st;
        logic [31:0] addr;
        logic [31:0] data;
        logic [31:0] tag;
        logic [31:0] rdata;
        int          dly;
        int          rst_at;
    } tb_op_t;

    typedef struct {
        int          cyc;
        logic        is_st;
        logic [31:0] tag;
        logic [31:0] data;
        logic        err;
    } exp_t;

    tb_op_t ld_q[$];
    tb_op_t st_q[$];
    exp_t   exp_q[$];

    int     checks   = 0;
    int     failures = 0;
    int     cyc      = 0;
    int     pres_pct = 100;
    bit     busy     = 0;
    bit     ld_pres  = 0;
    bit     st_pres  = 0;
    bit     clash    = 0;
    int     wcyc     = 0;
    tb_op_t cur;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cycle=%0d got=%0h expected=%0h", name, cyc, act, exp);
        end
    endtask

    // Load is older when, walking forward around the 2^32 ring from the load,
    // the store is reached within less than half the ring.
    function automatic bit ld_is_older(input logic [31:0] l, input logic [31:0] s);
        longint unsigned lv;
        longint unsigned sv;
        longint unsigned fwd;
        lv  = {32'h0, l};
        sv  = {32'h0, s};
        fwd = (sv + 64'h1_0000_0000 - lv) % 64'h1_0000_0000;
        return (fwd != 0) && (fwd < 64'h8000_0000);
    endfunction

    function automatic tb_op_t mk(input logic is_st, input logic [31:0] addr, input logic [31:0] data,
                                  input logic [31:0] tag, input logic [31:0] rdata,
                                  input int dly, input int rst_at);
        tb_op_t o;
        o.is_st = is_st; o.addr = addr; o.data = data; o.tag = tag;
        o.rdata = rdata; o.dly = dly; o.rst_at = rst_at;
        return o;
    endfunction

    // One clock cycle of stimulus, memory model and reference model.
    task automatic step();
        bit          do_rst;
        bit          ack;
        bit          cmpl;
        bit          err;
        bit          erd;
        bit          esr;
        logic [31:0] rd;
        exp_t        e;
        @(negedge clk);
        cyc++;
        do_rst = 0; ack = 0; cmpl = 0; err = 0; rd = $urandom;

        if (!ld_pres && ld_q.size() > 0 && $urandom_range(99) < pres_pct) ld_pres = 1;
        if (!st_pres && st_q.size() > 0 && $urandom_range(99) < pres_pct) st_pres = 1;
        ld_req = ld_pres;
        st_req = st_pres;
        if (ld_pres) begin ld_addr = ld_q[0].addr; ld_tag = ld_q[0].tag; end
        if (st_pres) begin st_addr = st_q[0].addr; st_data = st_q[0].data; st_tag = st_q[0].tag; end

        if (busy) begin
            wcyc++;
            chk("mem_req_wait", mem_req, 1);
            chk("mem_we", mem_we, cur.is_st);
            chk("mem_addr", mem_addr, cur.addr);
            chk("mem_wdata", mem_wdata, cur.is_st ? cur.data : 32'h0);
            if (cur.rst_at == wcyc) do_rst = 1;
            else if (cur.dly == wcyc) begin ack = 1; rd = cur.rdata; cmpl = 1; end
            else if (wcyc == TO) begin cmpl = 1; err = 1; end
        end else begin
            chk("mem_req_idle", mem_req, 0);
            ack = ($urandom_range(3) == 0);   // stray ack while idle must be ignored
        end
        rst       = do_rst;
        mem_ack   = ack;
        mem_rdata = rd;

        #1;
        erd = 0; esr = 0;
        if (!busy && !do_rst) begin
            if (ld_pres && st_pres) begin
                if (ld_is_older(ld_q[0].tag, st_q[0].tag)) erd = 1; else esr = 1;
            end else if (ld_pres) erd = 1;
            else if (st_pres) esr = 1;
        end
        chk("ld_ready", ld_ready, erd);
        chk("st_ready", st_ready, esr);
        chk("tag_clash", tag_clash, clash);

        if (do_rst) begin
            busy  = 0;
            clash = 0;
            cur.rst_at = 0;
            if (cur.is_st && !st_pres) begin st_q.push_front(cur); st_pres = 1; end
            if (!cur.is_st && !ld_pres) begin ld_q.push_front(cur); ld_pres = 1; end
        end else begin
            if (ld_pres && st_pres && ld_q[0].tag == st_q[0].tag) clash = 1;
            if (cmpl) begin
                e.cyc = cyc + 1; e.is_st = cur.is_st; e.tag = cur.tag; e.err = err;
                e.data = (err || cur.is_st) ? 32'h0 : rd;
                exp_q.push_back(e);
                busy = 0;
            end
            if (esr) begin cur = st_q.pop_front(); st_pres = 0; busy = 1; wcyc = 0; end
            else if (erd) begin cur = ld_q.pop_front(); ld_pres = 0; busy = 1; wcyc = 0; end
        end
    endtask

    task automatic run_drain(input int max_cyc);
        int n;
        n = 0;
        while ((ld_q.size() > 0 || st_q.size() > 0 || busy) && n < max_cyc) begin
            step();
            n++;
        end
        if (n >= max_cyc) begin
            checks++;
            failures++;
            $display("FAIL drain_timeout cycle=%0d got=%0d expected=<%0d cycles", cyc, n, max_cyc);
        end
        step();
        step();
    endtask

    // Completion monitor: pops the scoreboard whenever the DUT shows done.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (done) begin
                if (exp_q.size() == 0) begin
                    chk("done_unexpected", done, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("done_cycle", cyc, e.cyc);
                    chk("done_tag", done_tag, e.tag);
                    chk("done_is_st", done_is_st, e.is_st);
                    chk("done_data", done_data, e.data);
                    chk("done_err", done_err, e.err);
                end
            end else begin
                chk("done_is_st_idle", done_is_st, 0);
                chk("done_err_idle", done_err, 0);
                if (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
                    chk("done_missing", done, 1);
                    void'(exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_mem_req", mem_req, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_done", done, 0);
        chk("rst_done_tag", done_tag, 0);
        chk("rst_done_data", done_data, 0);
        chk("rst_tag_clash", tag_clash, 0);
        chk("rst_ld_ready", ld_ready, 0);
        chk("rst_st_ready", st_ready, 0);

        // Load only, ack on the third WAIT cycle.
        ld_q.push_back(mk(0, 32'h40, 32'h0, 32'd5, 32'hDEADBEEF, 3, 0));
        run_drain(100);
        // Both requesting: store 7 is older than load 9.
        st_q.push_back(mk(1, 32'h100, 32'hA5A5_0001, 32'd7, 32'h0, 2, 0));
        ld_q.push_back(mk(0, 32'h200, 32'h0, 32'd9, 32'h1234_5678, 1, 0));
        run_drain(100);
        // Wrap: store 0xFFFFFFFE precedes load 0x2.
        st_q.push_back(mk(1, 32'h300, 32'h0BAD_F00D, 32'hFFFF_FFFE, 32'h0, 1, 0));
        ld_q.push_back(mk(0, 32'h304, 32'h0, 32'h0000_0002, 32'hCAFE_0002, 2, 0));
        run_drain(100);
        // Timeout: memory never acks.
        ld_q.push_back(mk(0, 32'h400, 32'h0, 32'd20, 32'hFFFF_FFFF, 99, 0));
        run_drain(100);
        // Equal tags: store wins and the clash flag sticks.
        st_q.push_back(mk(1, 32'h500, 32'h5555_AAAA, 32'd12, 32'h0, 2, 0));
        ld_q.push_back(mk(0, 32'h504, 32'h0, 32'd12, 32'h7777_0000, 2, 0));
        run_drain(100);
        // Reset on WAIT cycle 2; the load is re-offered afterwards.
        ld_q.push_back(mk(0, 32'h600, 32'h0, 32'd30, 32'h6060_6060, 5, 2));
        run_drain(100);

        // Randomized traffic with wrap-heavy tags, timeouts and occasional resets.
        pres_pct = 60;
        for (int i = 0; i < 150; i++) begin
            tb_op_t o;
            o.is_st  = $urandom_range(1);
            o.addr   = $urandom;
            o.data   = $urandom;
            o.tag    = (i % 2 == 0) ? $urandom : (32'hFFFF_FFF8 + $urandom_range(0, 15));
            o.rdata  = $urandom;
            o.dly    = $urandom_range(1, TO + 2);
            o.rst_at = ($urandom_range(19) == 0) ? $urandom_range(1, 3) : 0;
            if (o.is_st) st_q.push_back(o); else ld_q.push_back(o);
        end
        run_drain(20000);

        chk("scoreboard_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Schedules the single data-memory port between the load issue path and the store issue path of the superscalar back end.
- Grants the older head request by instruction number and drives a multi-cycle memory handshake.
- Returns completion (load data or store ack plus instruction number) toward ROB/CDB.
- Enforces program order between the two buffer heads and guards the port with a timeout.

Parameters:
ADDR_W, 32, memory address width
DATA_W, 32, memory data width
TAG_W, 32, instruction-number width, wrap-around ordered
TIMEOUT, 255, max cycles waiting for mem_ack before abort

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
ld_req  in  1  load head valid; held until ld_ready accepted
ld_addr  in  ADDR_W  load effective address
ld_tag  in  TAG_W  load instruction number
ld_ready  out  1  load accepted at this edge if ld_req
st_req  in  1  store head valid; held until st_ready accepted
st_addr  in  ADDR_W  store effective address
st_data  in  DATA_W  store data
st_tag  in  TAG_W  store instruction number
st_ready  out  1  store accepted at this edge if st_req
mem_req  out  1  memory request, held until ack
mem_we  out  1  1=write
mem_addr  out  ADDR_W  latched address
mem_wdata  out  DATA_W  latched store data
mem_rdata  in  DATA_W  read data, valid with mem_ack
mem_ack  in  1  memory completion, one cycle
done  out  1  one-cycle completion pulse
done_is_st  out  1  1=store completion, 0=load
done_tag  out  TAG_W  completing instruction number
done_data  out  DATA_W  load data (0 for stores or on error)
done_err  out  1  completion aborted by timeout
tag_clash  out  1  sticky: ld_tag==st_tag while both requested

Behaviour:
- Reset (rst=1 at edge): state IDLE; all outputs 0, including tag_clash; timeout counter 0. A reset during WAIT drops mem_req at that edge and produces no done pulse.
- States: IDLE, WAIT.
- IDLE selection (combinational, ld_ready/st_ready only in IDLE):
  - Only one requester: that one is selected.
  - Both requesting: the older wins. Older means $signed(a_tag - b_tag) < 0 computed in TAG_W bits, so ordering survives wrap.
  - Equal tags: store wins; tag_clash is set and stays set until rst.
  - At most one of ld_ready/st_ready is high in any cycle.
- Accept edge N (req && ready):
  - Latch addr, data, tag and op.
  - Next state WAIT; mem_req=1 from cycle N+1.
  - mem_we=1 for store; mem_wdata=0 for load.
- WAIT:
  - mem_req, mem_we, mem_addr and mem_wdata hold stable.
  - Counter increments every cycle without mem_ack.
- mem_ack sampled at edge M in WAIT:
  - mem_req drops; done=1 during cycle M+1; done_tag = latched tag; done_is_st = op.
  - Load: done_data = mem_rdata captured at M.
  - Next state IDLE.
  - Earliest next accept is edge M+1; earliest next mem_req is cycle M+2.
- Timeout: counter reaches TIMEOUT without ack → same as completion with done_err=1 and done_data=0; mem_req drops.
- A late mem_ack arriving in IDLE is ignored.
- A request withdrawn before acceptance (not protocol-legal) is simply not granted. No state change.
- done, done_err and done_is_st are 0 in every cycle without a completion. done_tag and done_data hold their last values.
- No back-pressure on done: the consumer must always accept it.

Decomposition:
- Package mem_arb_pkg holds:
  - state enum {IDLE, WAIT}
  - op encoding OP_LD=0 / OP_ST=1
  - function tag_older(a, b) with the wrap-aware compare
  - default width constants
- No sub-module: selection, FSM and counter fit in one module. tag_older is reused by the load buffer for its own ordering.

Test Plan:
- Load only: ld_req, addr 0x40, tag 5; mem_ack after 3 cycles with rdata 0xDEADBEEF → ld_ready 1 cycle; mem_req 3 cycles with we=0; done with tag 5, data 0xDEADBEEF, is_st 0.
- Both requesting: store tag 7, load tag 9 → st_ready first; load granted at the edge after the store done; two done pulses in order 7 then 9.
- Wrap: load tag 0x00000002, store tag 0xFFFFFFFE → store older and granted first.
- Timeout with TIMEOUT=4 and no mem_ack → mem_req high 4 cycles, done_err=1, done_data=0, back in IDLE; a later ack is ignored.
- Reset in WAIT cycle 2 → mem_req 0 the next cycle, no done pulse, ld_ready available after rst deasserts.
- Equal tags 12/12 → store granted and tag_clash=1, held until rst.
